// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and its round-robin picker.
package mem_port_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int MEM_BE_W = 4;
    // Widest byte address the request latch can hold.
    localparam int ADDR_W   = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_WAIT
    } arb_state_t;

    typedef struct packed {
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [MEM_BE_W-1:0] be;
    } mem_req_t;

    // Index following idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Kept generic so other shared resources can reuse it.
module rr_pick #(
    parameter int  NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    int   idx;
    logic found;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr_i) + off) % NREQ;
            if (!found && req_i[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant_o[IDX_W'(idx)]  = 1'b1;
                winner_o              = IDX_W'(idx);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-ported memory between NREQ
// requesters; one transaction (accept, access, fixed-latency response) at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0]                req_we,
    input  logic [NREQ-1:0][AW-1:0]        req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]    req_wdata,
    input  logic [NREQ-1:0][MEM_BE_W-1:0]  req_be,
    output logic [NREQ-1:0]                req_ready,
    output logic [NREQ-1:0]                rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           mem_rden,
    output logic                           mem_wren,
    output logic [AW-1:0]                  mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic [MEM_BE_W-1:0]            mem_be,
    input  logic [DATA_W-1:0]              mem_rdata
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] winner;
    logic             any_req;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner),
        .valid_o  (any_req)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        owner_d   = owner_q;
        req_ready = '0;
        rsp_valid = '0;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // No acceptance while reset is held: the grant would be lost.
                if (!rst && any_req) begin
                    req_ready   = grant;
                    req_d.we    = req_we[winner];
                    req_d.addr  = ADDR_W'(req_addr[winner]);
                    req_d.wdata = req_wdata[winner];
                    req_d.be    = req_be[winner];
                    owner_d     = winner;
                    rr_ptr_d    = IDX_W'(wrap_inc(int'(winner), NREQ));
                    state_d     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                mem_wren = req_q.we;
                mem_rden = !req_q.we;
                cnt_d    = CNT_W'(RD_LAT - 1);
                state_d  = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_valid[owner_q] = !rst;
                    state_d            = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Memory side is driven straight from the latch so it holds between accesses.
    assign mem_addr  = AW'(req_q.addr);
    assign mem_wdata = req_q.wdata;
    assign mem_be    = req_q.be;
    assign rsp_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            req_q    <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            owner_q  <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers issue requests, a reference model
// predicts grants, memory accesses and responses, and a monitor compares them.
module tb_mem_port_arbiter;

    localparam int NREQ   = 2;
    localparam int AW     = 32;
    localparam int RD_LAT = 3;

    logic                       clk;
    logic                       rst;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_we;
    logic [NREQ-1:0][AW-1:0]    req_addr;
    logic [NREQ-1:0][31:0]      req_wdata;
    logic [NREQ-1:0][3:0]       req_be;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            rsp_valid;
    logic [31:0]                rsp_rdata;
    logic                       mem_rden;
    logic                       mem_wren;
    logic [AW-1:0]              mem_addr;
    logic [31:0]                mem_wdata;
    logic [3:0]                 mem_be;
    logic [31:0]                mem_rdata;

    mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_rden  (mem_rden),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Environment memory: synchronous, data RD_LAT cycles after the read cycle.
    bit   [31:0] env_mem [1024];
    logic [31:0] rd_pipe [RD_LAT];
    logic        pre_valid = 1'b0;
    logic [9:0]  pre_idx   = '0;
    logic [31:0] pre_data  = '0;

    always @(posedge clk) begin
        if (pre_valid) env_mem[pre_idx] <= pre_data;
        else if (mem_wren) env_mem[mem_addr[11:2]] <= merge_be(env_mem[mem_addr[11:2]], mem_wdata, mem_be);
        rd_pipe[0] <= env_mem[mem_addr[11:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model state.
    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } txn_t;
    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int cyc; } exp_mem_t;
    typedef struct { int port; bit we; logic [31:0] rdata; int cyc; } exp_rsp_t;

    bit   [31:0] ref_mem [1024];
    txn_t        txq [NREQ][$];
    exp_mem_t    mem_q[$];
    exp_rsp_t    rsp_q[$];
    int          grant_log[$];
    int          m_ptr     = 0;
    int          next_free = 0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_be    = '0;

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int p;
            p = (ptr + k) % NREQ;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    // Monitor / scoreboard.
    initial begin
        exp_mem_t em;
        exp_rsp_t er;
        int       w;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_req_ready", req_ready, '0);
                check("rst_rsp_valid", rsp_valid, '0);
                mem_q.delete();
                rsp_q.delete();
                m_ptr     = 0;
                next_free = cyc + 1;
                exp_addr  = '0;
                exp_wdata = '0;
                exp_be    = '0;
            end else begin
                check("ready_onehot0", $onehot0(req_ready), 1);
                check("rsp_onehot0", $onehot0(rsp_valid), 1);
                check("rden_wren_excl", mem_rden & mem_wren, 0);
                check("mem_addr_hold", mem_addr, exp_addr);
                check("mem_wdata_hold", mem_wdata, exp_wdata);
                check("mem_be_hold", mem_be, exp_be);

                if (mem_rden || mem_wren) begin
                    if (mem_q.size() == 0) check("unexpected_strobe", {mem_rden, mem_wren}, 0);
                    else begin
                        em = mem_q.pop_front();
                        check("strobe_cycle", cyc, em.cyc);
                        check("strobe_wren", mem_wren, em.we);
                        check("strobe_addr", mem_addr, em.addr);
                        if (em.we) begin
                            check("strobe_wdata", mem_wdata, em.wdata);
                            check("strobe_be", mem_be, em.be);
                        end
                    end
                end else if (mem_q.size() > 0 && cyc >= mem_q[0].cyc) begin
                    check("missing_strobe", {mem_rden, mem_wren}, mem_q[0].we ? 2'b01 : 2'b10);
                    void'(mem_q.pop_front());
                end

                if (rsp_valid != '0) begin
                    if (rsp_q.size() == 0) check("unexpected_rsp", rsp_valid, '0);
                    else begin
                        er = rsp_q.pop_front();
                        check("rsp_owner", rsp_valid, NREQ'(1) << er.port);
                        check("rsp_cycle", cyc, er.cyc);
                        if (!er.we) check("rsp_rdata", rsp_rdata, er.rdata);
                    end
                end else if (rsp_q.size() > 0 && cyc >= rsp_q[0].cyc) begin
                    check("missing_rsp", rsp_valid, NREQ'(1) << rsp_q[0].port);
                    void'(rsp_q.pop_front());
                end

                if (req_ready != '0 || (req_valid != '0 && cyc >= next_free)) begin
                    w = pick(req_valid, m_ptr);
                    if (w < 0) check("ready_without_valid", req_ready, '0);
                    else begin
                        check("grant", req_ready, NREQ'(1) << w);
                        check("accept_spacing", cyc >= next_free, 1);
                        for (int p = 0; p < NREQ; p++)
                            if (req_ready[p]) grant_log.push_back(p);
                        mem_q.push_back('{req_we[w], req_addr[w], req_wdata[w], req_be[w], cyc + 1});
                        rsp_q.push_back('{w, req_we[w], ref_mem[req_addr[w][11:2]], cyc + 1 + RD_LAT});
                        if (req_we[w])
                            ref_mem[req_addr[w][11:2]] = merge_be(ref_mem[req_addr[w][11:2]],
                                                                  req_wdata[w], req_be[w]);
                        m_ptr     = (w + 1) % NREQ;
                        next_free = cyc + RD_LAT + 2;
                        exp_addr  = req_addr[w];
                        exp_wdata = req_wdata[w];
                        exp_be    = req_be[w];
                    end
                end
            end
        end
    end

    task automatic push_txn(input int p, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        txq[p].push_back('{we, addr, wdata, be});
    endtask

    // Present queued transactions of port p, holding each until accepted.
    task automatic drive(input int p, input int gap_max);
        txn_t t;
        bit   got;
        while (txq[p].size() > 0) begin
            t            = txq[p][0];
            req_valid[p] = 1'b1;
            req_we[p]    = t.we;
            req_addr[p]  = t.addr;
            req_wdata[p] = t.wdata;
            req_be[p]    = t.be;
            got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(negedge clk);
                if (req_ready[p]) got = 1'b1;
            end
            check($sformatf("accept_port%0d", p), got, 1);
            @(posedge clk); #1;
            void'(txq[p].pop_front());
            req_valid[p] = 1'b0;
            if (!got) txq[p].delete();
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("drain_rsp_q", rsp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        ref_mem[addr[11:2]] = data;
        pre_idx   = addr[11:2];
        pre_data  = data;
        pre_valid = 1'b1;
        @(posedge clk); #1;
        pre_valid = 1'b0;
    endtask

    // Abort a read from port p by asserting rst in its access cycle.
    task automatic reset_mid(input int p);
        bit got;
        int n0;
        req_valid[p] = 1'b1;
        req_we[p]    = 1'b0;
        req_addr[p]  = 32'h300;
        req_wdata[p] = '0;
        req_be[p]    = 4'hf;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
        end
        check("rst_test_accept", got, 1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rden", mem_rden, 0);
        check("abort_wren", mem_wren, 0);
        check("abort_rsp", rsp_valid, '0);
        check("abort_ready", req_ready, '0);
        check("abort_addr", mem_addr, '0);
        n0 = grant_log.size();
        push_txn(0, 1'b0, 32'h104, '0, 4'hf);
        push_txn(1, 1'b0, 32'h108, '0, 4'hf);
        fork
            drive(0, 0);
            drive(1, 0);
        join
        drain();
        check("post_reset_first_grant", (grant_log.size() > n0) ? grant_log[n0] : -1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        preload(32'h100, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rden", mem_rden, 0);
        check("reset_wren", mem_wren, 0);
        check("reset_addr", mem_addr, '0);
        check("reset_wdata", mem_wdata, '0);
        check("reset_be", mem_be, '0);
        check("reset_ready", req_ready, '0);
        check("reset_rsp", rsp_valid, '0);

        // Single read, then a partial write by port 1.
        push_txn(0, 1'b0, 32'h100, '0, 4'hf);
        drive(0, 0);
        drain();
        push_txn(1, 1'b1, 32'h200, 32'h11223344, 4'b0011);
        drive(1, 0);
        drain();

        // Contention: both ports continuously requesting.
        n0 = grant_log.size();
        for (int i = 0; i < 4; i++) begin
            push_txn(0, i[0], 32'h400 + 32'(i) * 4, $urandom, 4'hf);
            push_txn(1, 1'b0, 32'h440 + 32'(i) * 4, '0, 4'hf);
        end
        fork
            drive(0, 0);
            drive(1, 0);
        join
        drain();
        check("contention_grants", grant_log.size() - n0, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("grant_order_%0d", i),
                  (n0 + i < grant_log.size()) ? grant_log[n0 + i] : -1, i % 2);

        // Readback of the partial write.
        push_txn(0, 1'b0, 32'h200, '0, 4'hf);
        drive(0, 0);
        drain();

        reset_mid(1);
        reset_mid(0);

        // Idle hold, then a lone request.
        repeat (10) @(posedge clk);
        #1;
        push_txn(1, 1'b0, 32'h100, '0, 4'hf);
        drive(1, 0);
        drain();

        // Randomized traffic on a small address window so reads hit earlier writes.
        for (int p = 0; p < NREQ; p++)
            for (int i = 0; i < 30; i++)
                push_txn(p, 1'($urandom_range(0, 1)), 32'h800 + 32'($urandom_range(0, 7)) * 4,
                         $urandom, 4'($urandom_range(0, 15)));
        fork
            drive(0, 3);
            drive(1, 3);
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-ported synchronous memory between NREQ requesters: port 0 is the core's mem_rden/mem_wren path, port 1 is a loader/debug master.
- Each request is a full transaction: accept, one memory access cycle, then a response after a fixed latency.
- Round-robin arbitration. One transaction is outstanding at a time.
- Sits between requesters and the memory macro; the core's done input is driven from this block's rsp_valid.

Parameters:
- NREQ, 2, number of requester ports (>=2)
- AW, 32, address width
- RD_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid RD_LAT cycles after the mem_rden cycle

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request pending, per port
- req_we  in  NREQ  1=write, 0=read
- req_addr  in  NREQ x AW  byte address
- req_wdata  in  NREQ x 32  write data
- req_be  in  NREQ x 4  byte enables
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- rsp_valid  out  NREQ  transaction complete, one-cycle pulse (one-hot or zero)
- rsp_rdata  out  32  read data, valid with rsp_valid of a read
- mem_rden  out  1  memory read strobe
- mem_wren  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  32  memory read data

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0 (port 0 highest priority), wait counter=0.
  - req_ready, rsp_valid, mem_rden and mem_wren are all 0.
  - Latched addr, wdata, be and owner are 0, so mem_addr, mem_wdata and mem_be are 0.
  - rst mid-transaction aborts it with no rsp_valid; the memory strobe drops in the next cycle.
- Handshake: valid/ready.
  - A requester holds req_* stable while req_valid=1 until it sees req_ready=1.
  - A requester does not withdraw req_valid before acceptance.
  - The arbiter only reads req_* in IDLE.
- State IDLE:
  - Winner = first port with req_valid=1, searching from rr_ptr upward mod NREQ.
  - req_ready[winner]=1 combinationally in the same cycle.
  - Latch we, addr, wdata, be and owner; rr_ptr <= (winner+1) mod NREQ; go to ACCESS.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- State ACCESS (exactly 1 cycle):
  - mem_addr, mem_wdata and mem_be come from the latches.
  - mem_wren=we and mem_rden=!we.
  - Load the counter with RD_LAT-1; go to WAIT.
- State WAIT:
  - While counter!=0, decrement.
  - When counter==0: rsp_valid[owner]=1 and rsp_rdata=mem_rdata (pass-through), then go to IDLE.
  - Writes use identical timing; rsp_rdata is don't-care for writes and is driven with mem_rdata.
- Latency: accept at cycle t, memory strobe at t+1, rsp_valid at t+1+RD_LAT.
  - Next acceptance is possible at t+2+RD_LAT.
  - Throughput is one transaction per RD_LAT+2 cycles.
- Outside ACCESS:
  - mem_rden=mem_wren=0.
  - mem_addr, mem_wdata and mem_be hold their latched values; they are not glitched to 0.
- Simultaneous requests: exactly one req_ready per IDLE cycle; losers wait.
  - With both ports continuously requesting, grants alternate 0,1,0,1.
- A requester may re-request in the cycle after its rsp_valid; it is arbitrated normally.
- rr_ptr wraps from NREQ-1 to 0.
- Never assert mem_rden and mem_wren together. Never assert more than one req_ready bit or more than one rsp_valid bit.

Decomposition:
- Shared package:
  - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_WAIT}
  - mem_req_t struct {we, addr, wdata, be}
  - MEM_BE_W=4 and DATA_W=32 constants
- One sub-module: rr_pick.
  - Combinational.
  - Inputs: NREQ request vector, rr_ptr.
  - Outputs: one-hot grant and winner index.
  - Reusable for future shared resources.

Test Plan:
- Single read, RD_LAT=1:
  - Stimulus: port0 reads addr 0x100 at t; the memory model returns 0xDEADBEEF.
  - Required: req_ready[0] at t; mem_rden=1 with mem_addr=0x100 at t+1; rsp_valid[0]=1 and rsp_rdata=0xDEADBEEF at t+2; idle afterward.
- Write with byte enables:
  - Stimulus: port1 writes 0x11223344 with be=4'b0011 to 0x200.
  - Required: mem_wren=1 with mem_wdata=0x11223344 and mem_be=0011 at t+1; rsp_valid[1] at t+2; a readback by port0 returns 0x00003344 when the memory was initialised to 0.
- Contention:
  - Stimulus: both ports hold req_valid for 4 transactions each.
  - Required: grant order 0,1,0,1,0,1,0,1; no two req_ready bits in the same cycle; each response goes to its owner.
- Latency parameter:
  - Stimulus: RD_LAT=3, single read at t.
  - Required: mem_rden at t+1, rsp_valid at t+4, next accept no earlier than t+5.
- Reset mid-operation:
  - Stimulus: assert rst in the ACCESS cycle of a port1 read.
  - Required: next cycle all strobes, rsp_valid and req_ready are 0; no response is issued; with both ports requesting after reset, port 0 wins first.
- Idle hold:
  - Stimulus: no req_valid for 10 cycles.
  - Required: no strobes; rr_ptr unchanged; mem_addr holds its last latched value.
